acr_rd_arbiter: RTL and testbench



---
 rtl/acr_rd_arbiter.sv | 177 +++++++++++++++++
 tb/tb_acr_rd_arbiter.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/acr_rd_arbiter.sv
// Read-channel arbiter: shares one AXI AR/R pair between NUM_REQ fetch engines.
// Round-robin AR grant with a per-requester outstanding-burst cap; R beats are routed by RID.
module acr_rd_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int MAX_OUTST = 4
) (
  input  logic                   acr_clk,
  input  logic                   acr_rst,
  input  logic [NUM_REQ-1:0]     req_valid,
  output logic [NUM_REQ-1:0]     req_ready,
  input  logic [NUM_REQ*32-1:0]  req_addr,
  input  logic [NUM_REQ*4-1:0]   req_len,
  output logic [7:0]             axi_arid,
  output logic [31:0]            axi_araddr,
  output logic [3:0]             axi_arlen,
  output logic [2:0]             axi_arsize,
  output logic [1:0]             axi_arburst,
  output logic                   axi_arlock,
  output logic [3:0]             axi_arcache,
  output logic [2:0]             axi_arprot,
  output logic                   axi_arvalid,
  input  logic                   axi_arready,
  input  logic [7:0]             axi_rid,
  input  logic [63:0]            axi_rdata,
  input  logic [1:0]             axi_rresp,
  input  logic                   axi_rlast,
  input  logic                   axi_rvalid,
  output logic                   axi_rready,
  output logic [NUM_REQ-1:0]     rsp_valid,
  input  logic [NUM_REQ-1:0]     rsp_ready,
  output logic [63:0]            rsp_data,
  output logic [1:0]             rsp_resp,
  output logic                   rsp_last,
  output logic                   err_bad_id
);

  localparam int CNT_W = $clog2(MAX_OUTST + 1);
  localparam int IDX_W = $clog2(NUM_REQ);

  typedef enum logic {IDLE, ISSUE} state_t;

  state_t             state, state_nxt;
  logic [IDX_W-1:0]   rr_ptr, rr_ptr_nxt;
  logic [CNT_W-1:0]   outst [NUM_REQ];
  logic [NUM_REQ-1:0] elig, inc, dec;
  logic [IDX_W-1:0]   win, idx;
  logic               win_vld, grant_ld, id_ok, bad_beat;
  logic [31:0]        addr_sel;
  logic [3:0]         len_sel;

  logic [IDX_W-1:0]   ar_id_p0;
  logic [31:0]        ar_addr_p0;
  logic [3:0]         ar_len_p0;

  always_comb begin
    for (int k = 0; k < NUM_REQ; k++) begin
      elig[k] = req_valid[k] && (outst[k] < CNT_W'(MAX_OUTST));
    end
  end

  // First eligible requester at or after rr_ptr, wrapping
  always_comb begin
    win     = '0;
    win_vld = 1'b0;
    idx     = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = IDX_W'((int'(rr_ptr) + i) % NUM_REQ);
      if (!win_vld && elig[idx]) begin
        win     = idx;
        win_vld = 1'b1;
      end
    end
  end

  always_comb begin
    addr_sel = '0;
    len_sel  = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (win == IDX_W'(k)) begin
        addr_sel = req_addr[k*32 +: 32];
        len_sel  = req_len[k*4 +: 4];
      end
    end
  end

  always_comb begin
    state_nxt  = state;
    rr_ptr_nxt = rr_ptr;
    req_ready  = '0;
    grant_ld   = 1'b0;
    case (state)
      IDLE: begin
        if (win_vld && !acr_rst) begin
          req_ready[win] = 1'b1;
          grant_ld       = 1'b1;
          rr_ptr_nxt     = (win == IDX_W'(NUM_REQ - 1)) ? '0 : win + 1'b1;
          state_nxt      = ISSUE;
        end
      end
      ISSUE: begin
        if (axi_arready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Stage p0: AR address-phase registers, held stable through back-pressure
  always_ff @(posedge acr_clk) begin
    if (acr_rst) begin
      state      <= IDLE;
      rr_ptr     <= '0;
      ar_id_p0   <= '0;
      ar_addr_p0 <= '0;
      ar_len_p0  <= '0;
      err_bad_id <= 1'b0;
    end else begin
      state  <= state_nxt;
      rr_ptr <= rr_ptr_nxt;
      if (grant_ld) begin
        ar_id_p0   <= win;
        ar_addr_p0 <= addr_sel & ~32'h7;
        ar_len_p0  <= len_sel;
      end
      if (bad_beat) err_bad_id <= 1'b1;
    end
  end

  // Unknown RIDs are swallowed so a misrouted beat can never stall the bus
  always_comb begin
    id_ok      = axi_rid < 8'(NUM_REQ);
    axi_rready = !id_ok;
    rsp_valid  = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (axi_rid == 8'(k)) begin
        axi_rready   = rsp_ready[k];
        rsp_valid[k] = axi_rvalid;
      end
    end
    bad_beat = axi_rvalid && !id_ok;
  end

  always_comb begin
    for (int k = 0; k < NUM_REQ; k++) begin
      inc[k] = (state == ISSUE) && axi_arready && (ar_id_p0 == IDX_W'(k));
      dec[k] = axi_rvalid && axi_rready && axi_rlast && (axi_rid == 8'(k));
    end
  end

  always_ff @(posedge acr_clk) begin
    if (acr_rst) begin
      for (int k = 0; k < NUM_REQ; k++) outst[k] <= '0;
    end else begin
      for (int k = 0; k < NUM_REQ; k++) begin
        if (inc[k] && !dec[k]) begin
          outst[k] <= outst[k] + 1'b1;
        end else if (dec[k] && !inc[k] && (outst[k] != '0)) begin
          outst[k] <= outst[k] - 1'b1;
        end
      end
    end
  end

  assign axi_arid    = 8'(ar_id_p0);
  assign axi_araddr  = ar_addr_p0;
  assign axi_arlen   = ar_len_p0;
  assign axi_arsize  = 3'b011;
  assign axi_arburst = 2'b01;
  assign axi_arlock  = 1'b0;
  assign axi_arcache = 4'b0011;
  assign axi_arprot  = 3'b000;
  assign axi_arvalid = (state == ISSUE);

  assign rsp_data = axi_rdata;
  assign rsp_resp = axi_rresp;
  assign rsp_last = axi_rlast;

endmodule

// File: tb/tb_acr_rd_arbiter.sv
// Randomized bench for acr_rd_arbiter: reference model predicts grants, AR contents and R routing;
// expected ARs go through a scoreboard queue consumed by an independent AR monitor.
module tb_acr_rd_arbiter;
  localparam int N    = 4;
  localparam int MAXO = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req_valid, req_ready;
  logic [N*32-1:0] req_addr;
  logic [N*4-1:0]  req_len;
  logic [7:0]      axi_arid;
  logic [31:0]     axi_araddr;
  logic [3:0]      axi_arlen;
  logic [2:0]      axi_arsize;
  logic [1:0]      axi_arburst;
  logic            axi_arlock;
  logic [3:0]      axi_arcache;
  logic [2:0]      axi_arprot;
  logic            axi_arvalid, axi_arready;
  logic [7:0]      axi_rid;
  logic [63:0]     axi_rdata;
  logic [1:0]      axi_rresp;
  logic            axi_rlast, axi_rvalid, axi_rready;
  logic [N-1:0]    rsp_valid, rsp_ready;
  logic [63:0]     rsp_data;
  logic [1:0]      rsp_resp;
  logic            rsp_last, err_bad_id;

  acr_rd_arbiter #(.NUM_REQ(N), .MAX_OUTST(MAXO)) dut (
    .acr_clk(clk), .acr_rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr), .req_len(req_len),
    .axi_arid(axi_arid), .axi_araddr(axi_araddr), .axi_arlen(axi_arlen), .axi_arsize(axi_arsize),
    .axi_arburst(axi_arburst), .axi_arlock(axi_arlock), .axi_arcache(axi_arcache),
    .axi_arprot(axi_arprot), .axi_arvalid(axi_arvalid), .axi_arready(axi_arready),
    .axi_rid(axi_rid), .axi_rdata(axi_rdata), .axi_rresp(axi_rresp), .axi_rlast(axi_rlast),
    .axi_rvalid(axi_rvalid), .axi_rready(axi_rready),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_resp(rsp_resp),
    .rsp_last(rsp_last), .err_bad_id(err_bad_id)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          id;
    logic [31:0] addr;
    logic [3:0]  len;
  } ar_t;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model state
  bit   m_busy, m_err;
  int   m_id, m_ptr;
  int   m_outst [N];
  ar_t  ar_q [$];

  // Stimulus knobs (percent) and slave/requester state
  int   p_req, p_ar, p_rv, p_rr, p_bad;
  logic [N-1:0] acc;
  bit   r_hs, drv_bad, cur_act;
  int   cur_id, cur_left;
  ar_t  sl_q [$];

  always @(negedge clk) begin : sampler
    acc  = req_valid & req_ready;
    r_hs = axi_rvalid && axi_rready;
    if (!rst && axi_arvalid && axi_arready)
      sl_q.push_back('{int'(axi_arid), axi_araddr, axi_arlen});
  end

  always @(negedge clk) begin : model
    logic [N-1:0] exp_rdy, exp_rv;
    bit exp_rr, up, dn;
    int win, idx, rid;
    if (rst) begin
      m_busy = 0; m_err = 0; m_ptr = 0; m_id = 0;
      for (int k = 0; k < N; k++) m_outst[k] = 0;
      ar_q.delete();
    end else begin
      exp_rdy = '0;
      win = -1;
      if (!m_busy) begin
        for (int i = 0; i < N; i++) begin
          idx = (m_ptr + i) % N;
          if (win < 0 && req_valid[idx] && m_outst[idx] < MAXO) win = idx;
        end
      end
      if (win >= 0) exp_rdy[win] = 1'b1;
      check("req_ready", 64'(req_ready), 64'(exp_rdy));
      check("arvalid", 64'(axi_arvalid), 64'(m_busy));
      check("err_bad_id", 64'(err_bad_id), 64'(m_err));

      rid = int'(axi_rid);
      exp_rv = '0;
      exp_rr = 1'b1;
      if (rid < N) begin
        exp_rr = rsp_ready[rid];
        exp_rv[rid] = axi_rvalid;
      end
      check("rsp_valid", 64'(rsp_valid), 64'(exp_rv));
      check("axi_rready", 64'(axi_rready), 64'(exp_rr));
      if (axi_rvalid) begin
        check("rsp_data", rsp_data, axi_rdata);
        check("rsp_resp", 64'(rsp_resp), 64'(axi_rresp));
        check("rsp_last", 64'(rsp_last), 64'(axi_rlast));
      end

      if (axi_rvalid && rid >= N) m_err = 1;
      for (int k = 0; k < N; k++) begin
        up = m_busy && axi_arready && (m_id == k);
        dn = axi_rvalid && exp_rr && axi_rlast && (rid == k);
        if (up && !dn) m_outst[k]++;
        else if (dn && !up && m_outst[k] > 0) m_outst[k]--;
      end
      if (m_busy && axi_arready) m_busy = 0;
      if (win >= 0) begin
        ar_q.push_back('{win, req_addr[win*32 +: 32] & ~32'h7, req_len[win*4 +: 4]});
        m_busy = 1; m_id = win; m_ptr = (win + 1) % N;
      end
    end
  end

  logic [7:0]  pv_id;
  logic [31:0] pv_addr;
  logic [3:0]  pv_len;
  bit          pv_wait;

  always @(negedge clk) begin : ar_monitor
    ar_t e;
    if (rst) begin
      pv_wait = 0;
    end else begin
      if (pv_wait) begin
        check("ar_hold_valid", 64'(axi_arvalid), 64'd1);
        check("ar_hold_id", 64'(axi_arid), 64'(pv_id));
        check("ar_hold_addr", 64'(axi_araddr), 64'(pv_addr));
        check("ar_hold_len", 64'(axi_arlen), 64'(pv_len));
      end
      if (axi_arvalid && axi_arready) begin
        if (ar_q.size() == 0) begin
          n_vec++; n_err++;
          $display("FAIL ar_unexpected: got id %0d with no grant expected at %0t", axi_arid, $time);
        end else begin
          e = ar_q.pop_front();
          check("arid", 64'(axi_arid), 64'(e.id));
          check("araddr", 64'(axi_araddr), 64'(e.addr));
          check("arlen", 64'(axi_arlen), 64'(e.len));
          check("ar_const", {axi_arsize, axi_arburst, axi_arlock, axi_arcache, axi_arprot},
                {3'b011, 2'b01, 1'b0, 4'b0011, 3'b000});
        end
      end
      pv_wait = axi_arvalid && !axi_arready;
      pv_id   = axi_arid;
      pv_addr = axi_araddr;
      pv_len  = axi_arlen;
    end
  end

  task automatic step();
    ar_t b;
    @(posedge clk); #1;
    for (int k = 0; k < N; k++) begin
      if (!req_valid[k] || acc[k]) begin
        req_valid[k]       = ($urandom_range(99) < p_req);
        req_addr[k*32 +: 32] = $urandom;
        req_len[k*4 +: 4]    = 4'($urandom_range(15));
      end
      rsp_ready[k] = ($urandom_range(99) < p_rr);
    end
    axi_arready = ($urandom_range(99) < p_ar);
    if (axi_rvalid && r_hs) begin
      if (!drv_bad) begin
        cur_left--;
        if (cur_left == 0) cur_act = 0;
      end
      axi_rvalid = 1'b0;
    end
    if (!axi_rvalid && $urandom_range(99) < p_rv) begin
      if (!cur_act && sl_q.size() > 0) begin
        b = sl_q.pop_front();
        cur_id = b.id; cur_left = int'(b.len) + 1; cur_act = 1;
      end
      axi_rdata = {$urandom, $urandom};
      axi_rresp = 2'($urandom_range(3));
      if ($urandom_range(99) < p_bad) begin
        drv_bad = 1; axi_rid = 8'(N + $urandom_range(255 - N));
        axi_rlast = 1'($urandom_range(1)); axi_rvalid = 1'b1;
      end else if (cur_act) begin
        drv_bad = 0; axi_rid = 8'(cur_id);
        axi_rlast = (cur_left == 1); axi_rvalid = 1'b1;
      end
    end
  endtask

  task automatic run(input int cyc, input int pq, input int pa, input int pv, input int pr, input int pb);
    p_req = pq; p_ar = pa; p_rv = pv; p_rr = pr; p_bad = pb;
    for (int c = 0; c < cyc; c++) step();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req_valid = '0; axi_rvalid = 1'b0; axi_rlast = 1'b0;
    drv_bad = 0; cur_act = 0; cur_left = 0;
    sl_q.delete();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_arvalid", 64'(axi_arvalid), 64'd0);
    check("rst_araddr", 64'(axi_araddr), 64'd0);
    check("rst_arid", 64'(axi_arid), 64'd0);
    check("rst_arlen", 64'(axi_arlen), 64'd0);
    check("rst_err", 64'(err_bad_id), 64'd0);
    check("rst_req_ready", 64'(req_ready), 64'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    req_valid = '0; req_addr = '0; req_len = '0; rsp_ready = '0;
    axi_arready = 1'b0; axi_rid = '0; axi_rdata = '0; axi_rresp = '0;
    axi_rlast = 1'b0; axi_rvalid = 1'b0;
    drv_bad = 0; cur_act = 0; cur_id = 0; cur_left = 0;
    p_req = 0; p_ar = 0; p_rv = 0; p_rr = 0; p_bad = 0;
    repeat (2) @(posedge clk);
    do_reset();

    run(200, 100, 100, 60, 100, 0);   // round-robin, full request load
    run(120, 100, 100, 0, 100, 0);    // no R returned: counters saturate at the cap
    run(150, 100, 100, 80, 80, 0);    // slots released by rlast
    run(60, 90, 0, 50, 50, 0);        // AR stalled
    run(400, 60, 60, 60, 60, 3);      // mix with unknown RIDs

    p_ar = 0; p_req = 100;
    begin : wait_issue
      int t;
      for (t = 0; t < 200 && !axi_arvalid; t++) step();
      if (!axi_arvalid) begin
        n_vec++; n_err++;
        $display("FAIL wait_arvalid: no AR issued within 200 cycles");
      end
    end
    do_reset();                       // abandon the pending AR

    run(60, 100, 100, 0, 100, 0);     // counters and pointer must restart from zero
    run(1000, 50, 50, 50, 50, 2);
    run(600, 0, 100, 100, 100, 0);    // drain
    @(negedge clk);
    check("ar_q_drained", 64'(ar_q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
